out_port_reader: RTL and testbench

//   Consumer end of the CPU's 16-bit output port. Captures each CPU port write into a small FIFO.

---
 rtl/out_port_reader.sv | 85 ++++++++
 tb/tb_out_port_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/out_port_reader.sv
// Consumer end of the CPU output port: capture FIFO, valid/ready drain
// to a sink, and a pollable status word on the CPU input port.
module out_port_reader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_left;
  logic              ovf_q, ovf_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              pop, push, ovf_set;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);

  assign pop     = m_valid_q & m_ready;
  assign push    = cpu_we & (~full | pop);
  assign ovf_set = cpu_we & full & ~pop;

  // Output register reloads only from words already stored, which gives
  // the one-cycle show-ahead latency and keeps m_data stable on stall.
  always_comb begin
    cnt_left  = cnt_q - CNT_W'(pop);
    cnt_d     = cnt_left + CNT_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    m_valid_d = (cnt_left != '0);
    m_data_d  = m_valid_d ? mem_q[rd_ptr_d] : m_data_q;
    ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  always_comb begin
    cpu_in             = '0;
    cpu_in[CNT_W-1:0]  = cnt_q;
    cpu_in[DATA_W-3]   = ovf_q;
    cpu_in[DATA_W-2]   = empty;
    cpu_in[DATA_W-1]   = full;
  end

endmodule

// File: tb/tb_out_port_reader.sv
// Scoreboard bench for out_port_reader: stimulus queues expected sink
// words, a negedge monitor pops and compares on each handshake.
module tb_out_port_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_out = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_in;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] held = '0;

  out_port_reader #(.DATA_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(cpu_in), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input bit accept);
    cpu_out = w;
    cpu_we  = 1'b1;
    if (accept) sb_q.push_back(w);
    tick();
    cpu_we  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(empty && !m_valid) && n < 60) begin
      m_ready = (n % 3 != 2);
      tick();
      n++;
    end
    m_ready = 1'b0;
    check({name, "_drained"}, {14'd0, empty, m_valid}, 16'h0002);
    check({name, "_sb_left"}, 16'(sb_q.size()), 16'h0000);
  endtask

  // Monitor: every handshake pops the scoreboard; stalls must hold data.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", m_data, held);
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none", m_data);
        end else begin
          check("sink_data", m_data, sb_q.pop_front());
        end
      end
      stall_prev = m_valid && !m_ready;
      held = m_data;
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", {15'd0, m_valid}, 16'h0000);
    check("rst_data", m_data, 16'h0000);
    check("rst_flags", {14'd0, full, empty}, 16'h0001);
    check("rst_cpu_in", cpu_in, 16'h4000);
    #2 rst_n = 1'b1;
    tick();

    // 1: single word, one-cycle latency
    m_ready = 1'b1;
    push(16'h1234, 1'b1);
    check("t1_lat0_valid", {15'd0, m_valid}, 16'h0000);
    check("t1_cnt", cpu_in, 16'h0001);
    tick();
    check("t1_lat1_valid", {15'd0, m_valid}, 16'h0001);
    check("t1_lat1_data", m_data, 16'h1234);
    tick();
    check("t1_empty", cpu_in, 16'h4000);
    m_ready = 1'b0;

    // 2: fill to full, stall, drain in order
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i), 1'b1);
    check("t2_full", cpu_in, 16'h8008);
    tick();
    tick();
    tick();
    drain("t2");

    // 3: overflow drop, clear, set-wins
    for (int i = 0; i < 8; i++) push(16'hB000 + 16'(i), 1'b1);
    tick();
    push(16'hDEAD, 1'b0);
    check("t3_ovf", cpu_in, 16'hA008);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_clr", cpu_in, 16'h8008);
    ovf_clr = 1'b1;
    push(16'hDEAD, 1'b0);
    ovf_clr = 1'b0;
    check("t3_set_wins", cpu_in, 16'hA008);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_clr2", cpu_in, 16'h8008);

    // 4: push while full with simultaneous pop
    m_ready = 1'b1;
    push(16'hBEEF, 1'b1);
    m_ready = 1'b0;
    check("t4_full_keep", cpu_in, 16'h8008);
    drain("t34");

    // 5: continuous streaming across pointer wrap
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(16'h5000 + 16'(i), 1'b1);
      check("t5_cnt_le2", {15'd0, cpu_in[3:0] <= 4'd2}, 16'h0001);
    end
    m_ready = 1'b0;
    drain("t5");

    // 6: reset mid-drain
    for (int i = 0; i < 6; i++) push(16'hC000 + 16'(i), 1'b1);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t6_cnt5", cpu_in, 16'h0005);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", {15'd0, m_valid}, 16'h0000);
    sb_q.delete();
    #2 rst_n = 1'b1;
    tick();
    check("t6_after_rst", cpu_in, 16'h4000);
    check("t6_valid_low", {15'd0, m_valid}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
